// File: rtl/snake_game_controller.sv
// Snake game top-level sequencer: game-state FSM, speed-scaled game tick,
// and score/level bookkeeping with one score increment per tick window.
module snake_game_controller #(
    parameter int TICK_BASE   = 5000000,
    parameter int TICK_STEP   = 1000000,
    parameter int LEVEL_EVERY = 4,
    parameter int MAX_LEVEL   = 3,
    parameter int WIN_SCORE   = 15
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       REACHED_TARGET,
    input  logic       COLLISION,
    output logic       GAME_TICK,
    output logic       SPAWN_TARGET,
    output logic       SNAKE_RESET,
    output logic [3:0] SCORE,
    output logic [1:0] LEVEL,
    output logic [2:0] STATE
);

    localparam int CW = $clog2(TICK_BASE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_flag;
    logic          r_spawn;
    logic [3:0]    r_score;
    logic [1:0]    r_level;

    logic [CW-1:0] w_period_m1;
    logic          w_run;
    logic          w_tick;
    logic          w_inc;
    logic          w_at_win;
    logic          w_stay_run;
    logic          w_start_run;
    logic [3:0]    w_lvl_raw;

    // Terminal count of the tick counter for the current speed level
    always_comb begin
        case (r_level)
            2'd0:    w_period_m1 = CW'(TICK_BASE - 1);
            2'd1:    w_period_m1 = CW'(TICK_BASE - TICK_STEP - 1);
            2'd2:    w_period_m1 = CW'(TICK_BASE - 2 * TICK_STEP - 1);
            default: w_period_m1 = CW'(TICK_BASE - 3 * TICK_STEP - 1);
        endcase
    end

    assign w_run       = (r_state == S_RUN);
    assign w_at_win    = (r_score == 4'(WIN_SCORE));
    // >= rather than == so a level-up that shortens the period past the
    // current count still produces a tick on the next cycle.
    assign w_tick      = w_run && (r_cnt >= w_period_m1);
    assign w_inc       = w_run && REACHED_TARGET && !COLLISION && !r_flag && !w_at_win;
    // RUN persists into the next cycle only if no exit condition fires
    assign w_stay_run  = w_run && !COLLISION && !w_at_win && !PAUSE;
    assign w_start_run = (r_state == S_IDLE) && START;
    assign w_lvl_raw   = r_score / 4'(LEVEL_EVERY);

    // Game-state FSM
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (START) r_state <= S_RUN;
                S_RUN: begin
                    if (COLLISION)     r_state <= S_OVER;
                    else if (w_at_win) r_state <= S_WIN;
                    else if (PAUSE)    r_state <= S_PAUSE;
                end
                S_PAUSE: if (PAUSE) r_state <= S_RUN;
                S_OVER, S_WIN: if (START) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tick counter: advances only while RUN continues, so the value seen in
    // the cycle PAUSE is taken is the one restored on resume.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (w_start_run || w_tick) begin
            r_cnt <= '0;
        end else if (w_stay_run) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Score, per-window scored flag, target spawn pulse and speed level
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_score <= '0;
            r_flag  <= 1'b0;
            r_spawn <= 1'b0;
            r_level <= '0;
        end else if (w_start_run) begin
            r_score <= '0;
            r_flag  <= 1'b0;
            r_spawn <= 1'b1;
            r_level <= '0;
        end else begin
            r_spawn <= w_inc;
            r_flag  <= (r_flag && !w_tick) || w_inc;
            if (w_inc) r_score <= r_score + 4'd1;
            r_level <= (w_lvl_raw > 4'(MAX_LEVEL)) ? 2'(MAX_LEVEL) : w_lvl_raw[1:0];
        end
    end

    assign GAME_TICK    = w_tick;
    assign SPAWN_TARGET = r_spawn;
    assign SNAKE_RESET  = (r_state == S_IDLE);
    assign SCORE        = r_score;
    assign LEVEL        = r_level;
    assign STATE        = r_state;

endmodule

// File: tb/tb_snake_game_controller.sv
// Scoreboard bench for snake_game_controller: stimulus pushes expected tick,
// spawn and state snapshots; a negedge monitor pops and compares them.
module tb_snake_game_controller;

    logic       CLK;
    logic       RESET_N;
    logic       START;
    logic       PAUSE;
    logic       REACHED_TARGET;
    logic       COLLISION;
    logic       GAME_TICK;
    logic       SPAWN_TARGET;
    logic       SNAKE_RESET;
    logic [3:0] SCORE;
    logic [1:0] LEVEL;
    logic [2:0] STATE;

    snake_game_controller #(
        .TICK_BASE(20), .TICK_STEP(4), .LEVEL_EVERY(4), .MAX_LEVEL(3), .WIN_SCORE(15)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE),
        .REACHED_TARGET(REACHED_TARGET), .COLLISION(COLLISION),
        .GAME_TICK(GAME_TICK), .SPAWN_TARGET(SPAWN_TARGET), .SNAKE_RESET(SNAKE_RESET),
        .SCORE(SCORE), .LEVEL(LEVEL), .STATE(STATE)
    );

    typedef struct {
        int cyc; int st; int sc; int lv; int sr; bit pulses; bit chk_sc;
    } snap_t;
    typedef struct { int cyc; int sc; } spawn_t;

    int     tq[$];
    spawn_t sq[$];
    snap_t  nq[$];

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    bit done = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic snap(input int c, input int st, input int sc, input int lv,
                        input int sr, input bit p, input bit chk_sc);
        nq.push_back('{cyc: c, st: st, sc: sc, lv: lv, sr: sr, pulses: p, chk_sc: chk_sc});
    endtask

    task automatic exp_spawn(input int c, input int s);
        sq.push_back('{cyc: c, sc: s});
    endtask

    task automatic pulse_start(input int c);
        wait_cyc(c); START = 1'b1; step(); START = 1'b0;
    endtask

    task automatic pulse_pause(input int c);
        wait_cyc(c); PAUSE = 1'b1; step(); PAUSE = 1'b0;
    endtask

    task automatic pulse_rt(input int c);
        wait_cyc(c); REACHED_TARGET = 1'b1; step(); REACHED_TARGET = 1'b0;
    endtask

    // Monitor: every comparison lives here
    always @(negedge CLK) begin
        while (nq.size() > 0 && nq[0].cyc < cyc) begin
            nvec++; nerr++;
            $display("FAIL snap_missed: expected snapshot at cycle %0d, now %0d", nq[0].cyc, cyc);
            void'(nq.pop_front());
        end
        if (nq.size() > 0 && nq[0].cyc == cyc) begin
            nvec++;
            if (STATE != 3'(nq[0].st) || SNAKE_RESET != 1'(nq[0].sr) ||
                (nq[0].chk_sc && (SCORE != 4'(nq[0].sc) || LEVEL != 2'(nq[0].lv))) ||
                (nq[0].pulses && (GAME_TICK || SPAWN_TARGET))) begin
                nerr++;
                $display("FAIL snap@%0d: got state=%0d score=%0d level=%0d snake_reset=%0d tick=%0d spawn=%0d, want state=%0d score=%0d level=%0d snake_reset=%0d (score checked=%0d, pulses must be 0=%0d)",
                         cyc, STATE, SCORE, LEVEL, SNAKE_RESET, GAME_TICK, SPAWN_TARGET,
                         nq[0].st, nq[0].sc, nq[0].lv, nq[0].sr, nq[0].chk_sc, nq[0].pulses);
            end
            void'(nq.pop_front());
        end
        if (RESET_N) begin
            while (tq.size() > 0 && tq[0] < cyc) begin
                nvec++; nerr++;
                $display("FAIL tick_missing: no tick at cycle %0d (now %0d)", tq[0], cyc);
                void'(tq.pop_front());
            end
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                nvec++; nerr++;
                $display("FAIL spawn_missing: no spawn at cycle %0d for score %0d", sq[0].cyc, sq[0].sc);
                void'(sq.pop_front());
            end
            if (GAME_TICK) begin
                nvec++;
                if (tq.size() > 0 && tq[0] == cyc) void'(tq.pop_front());
                else begin
                    nerr++;
                    $display("FAIL tick_unexpected: tick at cycle %0d, next expected %0d",
                             cyc, (tq.size() > 0) ? tq[0] : -1);
                end
            end
            if (SPAWN_TARGET) begin
                nvec++;
                if (sq.size() > 0 && sq[0].cyc == cyc) begin
                    if (SCORE != 4'(sq[0].sc)) begin
                        nerr++;
                        $display("FAIL spawn_score@%0d: score=%0d, want %0d", cyc, SCORE, sq[0].sc);
                    end
                    void'(sq.pop_front());
                end else begin
                    nerr++;
                    $display("FAIL spawn_unexpected: spawn at cycle %0d, next expected %0d",
                             cyc, (sq.size() > 0) ? sq[0].cyc : -1);
                end
            end
        end
        if (done) begin
            nvec++;
            if (tq.size() != 0 || sq.size() != 0 || nq.size() != 0) begin
                nerr++;
                $display("FAIL leftover: ticks=%0d spawns=%0d snaps=%0d pending, want 0 0 0",
                         tq.size(), sq.size(), nq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end
    end

    initial begin
        int r, r2, r3;
        int t1[14] = '{19, 39, 59, 75, 91, 107, 123, 135, 147, 159, 171, 181, 189, 197};
        int pc[12] = '{61, 77, 93, 109, 125, 137, 149, 161, 179, 183, 191, 199};
        int t2[5]  = '{19, 39, 59, 75, 91};
        int pc2[5] = '{1, 21, 41, 61, 77};

        RESET_N = 1'b0; START = 1'b0; PAUSE = 1'b0;
        REACHED_TARGET = 1'b0; COLLISION = 1'b0;

        // Reset state, during and just after reset
        snap(2, 0, 0, 0, 1, 1, 1);
        snap(5, 0, 0, 0, 1, 1, 1);
        wait_cyc(4);
        RESET_N = 1'b1;

        // Run 1: START at cycle 6, first RUN cycle r; tick on the 20th RUN cycle
        r = 7;
        for (int i = 0; i < 14; i++) tq.push_back(r + t1[i]);
        exp_spawn(r, 0);
        snap(r, 1, 0, 0, 0, 0, 1);
        snap(r + 10, 1, 1, 0, 0, 0, 1);   // START mid-run ignored
        snap(r + 56, 1, 3, 0, 0, 0, 1);   // three scores from a 50-cycle hold
        snap(r + 63, 1, 4, 1, 0, 0, 1);
        snap(r + 127, 1, 8, 2, 0, 0, 1);
        snap(r + 181, 1, 12, 3, 0, 0, 1); // level 3 arrives with count already past 7
        snap(r + 200, 1, 15, 3, 0, 0, 1);
        snap(r + 201, 4, 15, 3, 0, 0, 1); // WIN one cycle after reaching 15
        snap(r + 230, 4, 15, 3, 0, 1, 1); // holds, no ticks
        pulse_start(r - 1);

        // Held REACHED_TARGET: scores at r+5, r+20, r+40
        wait_cyc(r + 5);
        REACHED_TARGET = 1'b1;
        exp_spawn(r + 6, 1); exp_spawn(r + 21, 2); exp_spawn(r + 41, 3);
        pulse_start(r + 9);
        REACHED_TARGET = 1'b1;
        wait_cyc(r + 55);
        REACHED_TARGET = 1'b0;

        // One pulse per tick window up to 15
        for (int i = 0; i < 12; i++) begin
            exp_spawn(r + pc[i] + 1, 4 + i);
            pulse_rt(r + pc[i]);
        end

        // WIN -> IDLE -> RUN
        snap(r + 232, 0, 0, 0, 1, 0, 0);
        pulse_start(r + 231);
        r2 = r + 236;
        for (int i = 0; i < 5; i++) tq.push_back(r2 + t2[i]);
        exp_spawn(r2, 0);
        snap(r2, 1, 0, 0, 0, 0, 1);
        snap(r2 + 94, 3, 5, 1, 0, 0, 1);  // collision beats target
        snap(r2 + 110, 3, 5, 1, 0, 1, 1);
        pulse_start(r + 235);
        for (int i = 0; i < 5; i++) begin
            exp_spawn(r2 + pc2[i] + 1, 1 + i);
            pulse_rt(r2 + pc2[i]);
        end
        wait_cyc(r2 + 93);
        REACHED_TARGET = 1'b1; COLLISION = 1'b1;
        step();
        REACHED_TARGET = 1'b0; COLLISION = 1'b0;

        // OVER -> IDLE -> RUN, then pause at count 7
        snap(r2 + 112, 0, 0, 0, 1, 0, 0);
        pulse_start(r2 + 111);
        r3 = r2 + 116;
        exp_spawn(r3, 0);
        tq.push_back(r3 + 121);           // 13 cycles after the resume pulse
        snap(r3, 1, 0, 0, 0, 0, 1);
        snap(r3 + 8, 2, 0, 0, 0, 1, 1);
        snap(r3 + 107, 2, 0, 0, 0, 1, 1);
        snap(r3 + 109, 1, 0, 0, 0, 0, 1);
        snap(r3 + 129, 0, 0, 0, 1, 1, 1); // async reset lands mid-cycle
        snap(r3 + 130, 0, 0, 0, 1, 1, 1);
        snap(r3 + 133, 0, 0, 0, 1, 1, 1);
        pulse_start(r2 + 115);
        pulse_pause(r3 + 7);
        pulse_pause(r3 + 108);

        // Reset with a score increment pending
        wait_cyc(r3 + 129);
        REACHED_TARGET = 1'b1;
        #2;
        RESET_N = 1'b0;
        wait_cyc(r3 + 132);
        REACHED_TARGET = 1'b0;
        RESET_N = 1'b1;
        wait_cyc(r3 + 136);
        done = 1'b1;
    end

endmodule

// File: doc/snake_game_controller.md
Name: snake_game_controller

Overview:
Top-level sequencer for the snake game. It owns the game-state FSM (idle/run/pause/over/win), generates the single-cycle game tick from the system clock, and speeds the tick up as the score rises. It also keeps the score, limited to one increment per tick window, and requests a new target after each score.
It sits between the debounced buttons and the snake/target/collision logic, and replaces any separate score counter clocked from event edges.

Parameters:
TICK_BASE, 5000000, tick period in CLK cycles at level 0 (must exceed TICK_STEP*MAX_LEVEL+1)
TICK_STEP, 1000000, period reduction per level
LEVEL_EVERY, 4, points per level step
MAX_LEVEL, 3, level saturation value (LEVEL width 2)
WIN_SCORE, 15, score that ends the game in WIN (<= 15)

Ports:
CLK  in  1  system clock; only clock in the block
RESET_N  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse, debounced, synchronous to CLK
PAUSE  in  1  one-cycle pulse; toggles RUN<->PAUSE
REACHED_TARGET  in  1  level; snake head on target, valid in RUN
COLLISION  in  1  level; snake hit wall/self, valid in RUN
GAME_TICK  out  1  one-cycle pulse; advance snake
SPAWN_TARGET  out  1  one-cycle pulse; place a new target
SNAKE_RESET  out  1  high while in IDLE; snake logic holds its initial position
SCORE  out  4  current score
LEVEL  out  2  current speed level
STATE  out  3  IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4

Behaviour:
- Reset (RESET_N low, async): state IDLE, SCORE=0, LEVEL=0, tick counter=0, scored flag=0, GAME_TICK=0, SPAWN_TARGET=0, SNAKE_RESET=1.
- All registers are on posedge CLK. No logic is clocked by REACHED_TARGET or any other data signal.

FSM transitions, each evaluated on a clock edge:
- IDLE: START -> RUN. On entry to RUN from IDLE: SCORE=0, LEVEL=0, counter=0, flag=0, and SPAWN_TARGET pulses in the first RUN cycle.
- RUN: priority is COLLISION -> OVER, then score reaching WIN_SCORE -> WIN, then PAUSE -> PAUSE. START is ignored.
- PAUSE: PAUSE -> RUN. Counter frozen, no ticks, REACHED_TARGET and COLLISION ignored.
- OVER and WIN: START -> IDLE. SCORE and LEVEL hold their final values until then.
- Unused encodings (5-7) -> IDLE.

Tick generation:
- Counter runs only in RUN.
- period = TICK_BASE - LEVEL*TICK_STEP.
- GAME_TICK=1 for exactly one cycle when counter==period-1; the counter then wraps to 0.
- If LEVEL rises so that counter >= period-1, the next cycle ticks and the counter wraps.
- The counter is cleared on entry to RUN from IDLE and is preserved across PAUSE.

Scoring:
- inc = (state==RUN) & REACHED_TARGET & ~COLLISION & ~flag.
- On inc: SCORE+1 on the next edge, flag set, SPAWN_TARGET pulses in that same next cycle.
- flag_next = (flag & ~GAME_TICK) | inc. At most one increment per tick window, however long REACHED_TARGET stays high.
- Tick and REACHED_TARGET in the same cycle with flag=1: no increment; flag clears, so a still-high REACHED_TARGET scores in the following cycle.
- COLLISION and REACHED_TARGET together: collision wins, no increment.
- SCORE never wraps. When it reaches WIN_SCORE the FSM enters WIN one cycle later.
- LEVEL = min(SCORE / LEVEL_EVERY, MAX_LEVEL), registered; it updates one cycle after SCORE.

Asynchronous reset in any state, including mid-tick or mid-increment, restores all reset values immediately.

Test Plan:
Settings for all scenarios: TICK_BASE=20, TICK_STEP=4, LEVEL_EVERY=4, MAX_LEVEL=3, WIN_SCORE=15.
1. Reset then START -> STATE=1, SPAWN_TARGET pulses once. GAME_TICK first appears 20 cycles after RUN entry, then every 20 cycles; SNAKE_RESET=0.
2. REACHED_TARGET held high for 50 cycles across 3 ticks -> SCORE increments 3 times: once right away, then once in the cycle after each later tick (total 3). One SPAWN_TARGET per increment.
3. Drive SCORE to 4, then 8 -> LEVEL=1 with tick period 16, then LEVEL=2 with period 12. At SCORE 12, LEVEL=3 with period 8, and LEVEL stays at 3 afterwards.
4. Reach SCORE=15 -> STATE=4 one cycle later, GAME_TICK stops, SCORE holds at 15. START -> IDLE; a further START -> RUN with SCORE=0.
5. COLLISION and REACHED_TARGET in the same cycle at SCORE=5 -> STATE=3, SCORE stays 5, no SPAWN_TARGET.
6. PAUSE at counter=7, wait 100 cycles, PAUSE again -> no ticks while paused, next tick 13 cycles after resume. Then assert RESET_N low mid-run -> all outputs return to their reset values in the same cycle.
